// File: rtl/shared_bus_sequencer.sv
// Time-slot generator and access controller for the master/slave shared RAM bus.
// A 4-phase frame alternates slave and master slots; each CPU runs a request FSM that lands in its slot.
module shared_bus_sequencer #(
    parameter bit STEAL = 1'b0
) (
    input  logic CLK_6M,
    input  logic nRST,
    input  logic m_req,
    input  logic m_rnw,
    input  logic s_req,
    input  logic s_rnw,
    output logic CLK_1H,
    output logic CLK_2H,
    output logic CLK_S2H,
    output logic nMBUFEN,
    output logic nMLTH0,
    output logic nMLTH1,
    output logic nSBUFEN,
    output logic nSLTH0,
    output logic nSLTH1,
    output logic m_ack,
    output logic s_ack,
    output logic m_wait,
    output logic s_wait
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_GRANT,
        ST_ACCESS,
        ST_DONE
    } cpu_state_t;

    logic [1:0] r_ph;
    cpu_state_t r_m_st, r_s_st;
    logic       r_m_rnw, r_s_rnw;
    logic       r_m_req_d, r_s_req_d;
    logic       r_1h, r_2h, r_s2h;
    logic       r_mbufen_n, r_mlth0_n, r_mlth1_n;
    logic       r_sbufen_n, r_slth0_n, r_slth1_n;
    logic       r_m_ack, r_s_ack, r_m_wait, r_s_wait;

    logic [1:0] w_ph_nxt;
    cpu_state_t w_m_st_nxt, w_s_st_nxt;
    logic       w_m_rise, w_s_rise, w_m_eff, w_s_eff;
    logic       w_m_grant, w_s_grant;
    logic       w_m_rnw_nxt, w_s_rnw_nxt;
    logic       w_2h_nxt, w_s2h_nxt;

    function automatic cpu_state_t f_next(input cpu_state_t st, input logic rise,
                                          input logic grant, input logic req);
        cpu_state_t nxt;
        nxt = st;
        case (st)
            ST_IDLE:   if (grant) nxt = ST_GRANT; else if (rise) nxt = ST_PEND;
            ST_PEND:   if (grant) nxt = ST_GRANT;
            ST_GRANT:  nxt = ST_ACCESS;
            ST_ACCESS: nxt = ST_DONE;
            ST_DONE:   if (!req) nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_ph_nxt    = r_ph + 2'd1;
        w_m_rise    = m_req && !r_m_req_d;
        w_s_rise    = s_req && !r_s_req_d;
        // A request arriving on a decision edge competes for that slot immediately.
        w_m_eff     = (r_m_st == ST_PEND) || ((r_m_st == ST_IDLE) && w_m_rise);
        w_s_eff     = (r_s_st == ST_PEND) || ((r_s_st == ST_IDLE) && w_s_rise);
        w_m_grant   = ((w_ph_nxt == 2'b01) && w_m_eff) ||
                      (STEAL && (w_ph_nxt == 2'b11) && w_m_eff && !w_s_eff);
        w_s_grant   = ((w_ph_nxt == 2'b11) && w_s_eff) ||
                      (STEAL && (w_ph_nxt == 2'b01) && w_s_eff && !w_m_eff);
        w_m_rnw_nxt = ((r_m_st == ST_IDLE) && w_m_rise) ? m_rnw : r_m_rnw;
        w_s_rnw_nxt = ((r_s_st == ST_IDLE) && w_s_rise) ? s_rnw : r_s_rnw;
        w_m_st_nxt  = f_next(r_m_st, w_m_rise, w_m_grant, m_req);
        w_s_st_nxt  = f_next(r_s_st, w_s_rise, w_s_grant, s_req);

        // S2H follows the grantee of each decision phase and holds through its access phase.
        w_s2h_nxt = r_s2h;
        if (w_ph_nxt[0]) begin
            if (w_m_grant)      w_s2h_nxt = 1'b1;
            else if (w_s_grant) w_s2h_nxt = 1'b0;
            else                w_s2h_nxt = !w_ph_nxt[1];
        end

        // 2H follows the CPU actually accessing and holds into the following setup phase.
        w_2h_nxt = r_2h;
        if (!w_ph_nxt[0]) begin
            if (w_m_st_nxt == ST_ACCESS)      w_2h_nxt = 1'b1;
            else if (w_s_st_nxt == ST_ACCESS) w_2h_nxt = 1'b0;
            else                              w_2h_nxt = w_ph_nxt[1];
        end
    end

    always_ff @(posedge CLK_6M or negedge nRST) begin
        if (!nRST) begin
            r_ph       <= 2'b11;
            r_m_st     <= ST_IDLE;
            r_s_st     <= ST_IDLE;
            r_m_rnw    <= 1'b1;
            r_s_rnw    <= 1'b1;
            // Treat req as already seen so a req held through reset is not a new request.
            r_m_req_d  <= 1'b1;
            r_s_req_d  <= 1'b1;
            r_1h       <= 1'b1;
            r_2h       <= 1'b1;
            r_s2h      <= 1'b0;
            r_mbufen_n <= 1'b1;
            r_mlth0_n  <= 1'b1;
            r_mlth1_n  <= 1'b1;
            r_sbufen_n <= 1'b1;
            r_slth0_n  <= 1'b1;
            r_slth1_n  <= 1'b1;
            r_m_ack    <= 1'b0;
            r_s_ack    <= 1'b0;
            r_m_wait   <= 1'b0;
            r_s_wait   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            r_ph       <= w_ph_nxt;
            r_m_st     <= w_m_st_nxt;
            r_s_st     <= w_s_st_nxt;
            r_m_rnw    <= w_m_rnw_nxt;
            r_s_rnw    <= w_s_rnw_nxt;
            r_m_req_d  <= m_req;
            r_s_req_d  <= s_req;
            r_1h       <= w_ph_nxt[0];
            r_2h       <= w_2h_nxt;
            r_s2h      <= w_s2h_nxt;
            r_mbufen_n <= (w_m_st_nxt != ST_ACCESS);
            r_mlth0_n  <= !((w_m_st_nxt == ST_ACCESS) && w_m_rnw_nxt);
            r_mlth1_n  <= !((w_m_st_nxt == ST_GRANT) && !w_m_rnw_nxt);
            r_sbufen_n <= (w_s_st_nxt != ST_ACCESS);
            r_slth0_n  <= !((w_s_st_nxt == ST_ACCESS) && w_s_rnw_nxt);
            r_slth1_n  <= !((w_s_st_nxt == ST_GRANT) && !w_s_rnw_nxt);
            r_m_ack    <= (r_m_st == ST_ACCESS);
            r_s_ack    <= (r_s_st == ST_ACCESS);
            r_m_wait   <= (w_m_st_nxt == ST_PEND) || (w_m_st_nxt == ST_GRANT) ||
                          (w_m_st_nxt == ST_ACCESS);
            r_s_wait   <= (w_s_st_nxt == ST_PEND) || (w_s_st_nxt == ST_GRANT) ||
                          (w_s_st_nxt == ST_ACCESS);
        end
    end

    assign CLK_1H  = r_1h;
    assign CLK_2H  = r_2h;
    assign CLK_S2H = r_s2h;
    assign nMBUFEN = r_mbufen_n;
    assign nMLTH0  = r_mlth0_n;
    assign nMLTH1  = r_mlth1_n;
    assign nSBUFEN = r_sbufen_n;
    assign nSLTH0  = r_slth0_n;
    assign nSLTH1  = r_slth1_n;
    assign m_ack   = r_m_ack;
    assign s_ack   = r_s_ack;
    assign m_wait  = r_m_wait;
    assign s_wait  = r_s_wait;
endmodule

// File: tb/tb_shared_bus_sequencer.sv
// Bench for shared_bus_sequencer: one instance without and one with slot stealing, both
// checked every cycle against a slot-timeline model plus hand-computed spot checks.
module tb_shared_bus_sequencer;
    logic CLK_6M = 1'b0;
    logic nRST   = 1'b0;
    logic m_req  = 1'b0;
    logic m_rnw  = 1'b0;
    logic s_req  = 1'b0;
    logic s_rnw  = 1'b0;

    logic [1:0] c1h, c2h, cs2h, mbuf, mlth0, mlth1, sbuf, slth0, slth1, mack, sack, mwait, swait;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK_6M = ~CLK_6M;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        shared_bus_sequencer #(.STEAL(g == 1)) u_dut (
            .CLK_6M (CLK_6M),
            .nRST   (nRST),
            .m_req  (m_req),
            .m_rnw  (m_rnw),
            .s_req  (s_req),
            .s_rnw  (s_rnw),
            .CLK_1H (c1h[g]),
            .CLK_2H (c2h[g]),
            .CLK_S2H(cs2h[g]),
            .nMBUFEN(mbuf[g]),
            .nMLTH0 (mlth0[g]),
            .nMLTH1 (mlth1[g]),
            .nSBUFEN(sbuf[g]),
            .nSLTH0 (slth0[g]),
            .nSLTH1 (slth1[g]),
            .m_ack  (mack[g]),
            .s_ack  (sack[g]),
            .m_wait (mwait[g]),
            .s_wait (swait[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: cycle n is the state after n clock edges since reset release; cycle n has
    // phase (3+n)%4. Each CPU is pending, or has an access scheduled at cycle acc.
    int  cyc;
    bit  pend  [2][2];
    int  acc   [2][2];
    bit  rnw_q [2][2];
    bit  prev_q[2][2];
    byte owner [2][1024];
    int  ack_cnt[2][2];

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                pend[i][c]   = 1'b0;
                acc[i][c]    = -1;
                rnw_q[i][c]  = 1'b0;
                prev_q[i][c] = 1'b1;
            end
            for (int a = 0; a < 1024; a++) owner[i][a] = 0;
        end
    endtask

    task automatic model_edge(input int i, input int k);
        bit req[2];
        bit rn[2];
        bit eff[2];
        int g;
        req[0] = m_req; req[1] = s_req;
        rn[0]  = m_rnw; rn[1]  = s_rnw;
        owner[i][(k + 2) % 1024] = 0;
        for (int c = 0; c < 2; c++) begin
            if (acc[i][c] >= 0 && k >= acc[i][c] + 2 && !req[c]) acc[i][c] = -1;
            if (!pend[i][c] && acc[i][c] < 0 && req[c] && !prev_q[i][c]) begin
                pend[i][c]  = 1'b1;
                rnw_q[i][c] = rn[c];
            end
            eff[c]       = pend[i][c];
            prev_q[i][c] = req[c];
        end
        g = -1;
        if (k % 4 == 2) g = eff[0] ? 0 : ((i == 1 && eff[1]) ? 1 : -1);
        if (k % 4 == 0) g = eff[1] ? 1 : ((i == 1 && eff[0]) ? 0 : -1);
        if (g >= 0) begin
            pend[i][g]  = 1'b0;
            acc[i][g]   = k + 1;
            owner[i][(k + 1) % 1024] = byte'(g + 1);
        end
    endtask

    function automatic logic [12:0] exp_vec(input int i, input int n);
        int  ph, ac2, acs, a;
        bit  h2, hs;
        bit  bufn[2], l0n[2], l1n[2], ak[2], wt[2];
        ph  = (3 + n) % 4;
        ac2 = (ph % 2 == 0) ? n : n - 1;
        acs = (ph % 2 == 0) ? n : n + 1;
        h2  = (owner[i][ac2 % 1024] == 1) ? 1'b1 : (owner[i][ac2 % 1024] == 2) ? 1'b0 :
              ((3 + ac2) % 4 == 2);
        hs  = (owner[i][acs % 1024] == 1) ? 1'b1 : (owner[i][acs % 1024] == 2) ? 1'b0 :
              ((3 + acs) % 4 == 2);
        for (int c = 0; c < 2; c++) begin
            a       = acc[i][c];
            bufn[c] = !(a >= 0 && n == a);
            l0n[c]  = !(a >= 0 && n == a && rnw_q[i][c]);
            l1n[c]  = !(a >= 0 && n == a - 1 && !rnw_q[i][c]);
            ak[c]   = (a >= 0 && n == a + 1);
            wt[c]   = pend[i][c] || (a >= 0 && n <= a);
        end
        return {ph[0], h2, hs, bufn[0], l0n[0], l1n[0], bufn[1], l0n[1], l1n[1],
                ak[0], ak[1], wt[0], wt[1]};
    endfunction

    function automatic logic [12:0] dut_vec(input int i);
        return {c1h[i], c2h[i], cs2h[i], mbuf[i], mlth0[i], mlth1[i], sbuf[i], slth0[i],
                slth1[i], mack[i], sack[i], mwait[i], swait[i]};
    endfunction

    initial begin
        forever begin
            @(posedge CLK_6M or negedge nRST);
            if (!nRST) model_reset();
            else begin
                cyc++;
                for (int i = 0; i < 2; i++) model_edge(i, cyc);
            end
        end
    end

    bit chk_en = 1'b0;
    initial begin
        forever begin
            @(negedge CLK_6M);
            for (int i = 0; i < 2; i++) begin
                if (mack[i] === 1'b1) ack_cnt[i][0]++;
                if (sack[i] === 1'b1) ack_cnt[i][1]++;
                if (chk_en) begin
                    if (!nRST || cyc == 0)
                        check($sformatf("reset_vals u%0d", i), 32'(dut_vec(i)), 32'h1BF0);
                    else
                        check($sformatf("outputs u%0d cyc%0d", i, cyc), 32'(dut_vec(i)),
                              32'(exp_vec(i, cyc)));
                    check($sformatf("exclusive u%0d", i),
                          32'((!mbuf[i] || !mlth0[i] || !mlth1[i]) &&
                              (!sbuf[i] || !slth0[i] || !slth1[i])), 32'd0);
                end
            end
        end
    end

    task automatic clear_acks();
        for (int i = 0; i < 2; i++) begin
            ack_cnt[i][0] = 0;
            ack_cnt[i][1] = 0;
        end
    endtask

    // Leaves the caller 2 time units after a rising edge that starts a cycle of phase p.
    task automatic to_ph(input int p);
        @(posedge CLK_6M); #2;
        for (int t = 0; t < 4; t++) begin
            if ((3 + cyc) % 4 == p) break;
            @(posedge CLK_6M); #2;
        end
    endtask

    task automatic release_when_acked(input bit want_m, input bit want_s);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 30; t++) begin
            done = (!want_m || (ack_cnt[0][0] > 0 && ack_cnt[1][0] > 0)) &&
                   (!want_s || (ack_cnt[0][1] > 0 && ack_cnt[1][1] > 0));
            if (done) break;
            @(negedge CLK_6M);
        end
        check("ack_timeout", 32'(done), 32'd1);
        @(posedge CLK_6M); #2;
        if (want_m) m_req = 1'b0;
        if (want_s) s_req = 1'b0;
        @(posedge CLK_6M); #2;
    endtask

    typedef struct {
        int md;
        bit mr;
        int sd;
        bit sr;
    } pat_t;

    pat_t pats[5] = '{
        '{1, 1'b0, 3, 1'b1},
        '{2, 1'b1, 0, 1'b0},
        '{0, 1'b0, 5, 1'b1},
        '{3, 1'b1, 1, 1'b0},
        '{0, 1'b1, 0, 1'b1}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_acks();
        chk_en = 1'b1;
        repeat (3) @(posedge CLK_6M);
        #2 nRST = 1'b1;

        // First cycle after release is a slave access phase with no grant.
        @(negedge CLK_6M);
        @(negedge CLK_6M);
        check("first_ph00", 32'({c1h, c2h, cs2h}), 32'd0);
        repeat (16) @(posedge CLK_6M);

        // Master read requested in ph00.
        clear_acks();
        to_ph(0);
        m_req = 1'b1; m_rnw = 1'b1;
        @(negedge CLK_6M); check("m_wait_pre", 32'(mwait), 32'd0);
        @(negedge CLK_6M); check("m_grant_wait", 32'({mwait, mlth1}), 32'hF);
        @(negedge CLK_6M); check("m_access", 32'({mbuf, mlth0}), 32'd0);
        @(negedge CLK_6M); check("m_ack", 32'({mack, mwait}), 32'hC);
        release_when_acked(1'b1, 1'b0);

        // Both CPUs write, requested on the same edge.
        clear_acks();
        to_ph(0);
        m_req = 1'b1; m_rnw = 1'b0; s_req = 1'b1; s_rnw = 1'b0;
        @(negedge CLK_6M);
        @(negedge CLK_6M); check("both_ph01", 32'({mlth1[0], slth1[0]}), 32'd1);
        @(negedge CLK_6M); check("both_ph10", 32'({mbuf[0], sbuf[0]}), 32'd1);
        @(negedge CLK_6M); check("both_ph11", 32'({mack[0], mlth1[0], slth1[0]}), 32'd6);
        @(negedge CLK_6M); check("both_ph00", 32'({mbuf[0], sbuf[0]}), 32'd2);
        release_when_acked(1'b1, 1'b1);

        // Only the slave requests in ph00: the stealing instance takes the master slot.
        clear_acks();
        to_ph(0);
        s_req = 1'b1; s_rnw = 1'b1;
        @(negedge CLK_6M);
        @(negedge CLK_6M); check("steal_grant", 32'({swait[1], cs2h[1]}), 32'd2);
        @(negedge CLK_6M); check("steal_access", 32'({c2h[1], cs2h[1], sbuf[1], slth0[1]}), 32'd0);
        @(negedge CLK_6M); check("steal_ack", 32'({sack[1], c2h[1], sack[0]}), 32'd4);
        release_when_acked(1'b0, 1'b1);

        // Staggered request pairs.
        foreach (pats[p]) begin
            clear_acks();
            to_ph(0);
            fork
                begin
                    if (pats[p].md > 0) begin
                        repeat (pats[p].md) @(posedge CLK_6M);
                        #2;
                    end
                    m_req = 1'b1; m_rnw = pats[p].mr;
                end
                begin
                    if (pats[p].sd > 0) begin
                        repeat (pats[p].sd) @(posedge CLK_6M);
                        #2;
                    end
                    s_req = 1'b1; s_rnw = pats[p].sr;
                end
            join
            release_when_acked(1'b1, 1'b1);
        end

        // A request held long after its ack performs a single access.
        clear_acks();
        to_ph(0);
        m_req = 1'b1; m_rnw = 1'b0;
        repeat (20) @(posedge CLK_6M);
        #2;
        check("held_u0", 32'(ack_cnt[0][0]), 32'd1);
        check("held_u1", 32'(ack_cnt[1][0]), 32'd1);
        m_req = 1'b0;
        @(posedge CLK_6M); #2;
        clear_acks();
        m_req = 1'b1;
        release_when_acked(1'b1, 1'b0);
        check("second_access_u0", 32'(ack_cnt[0][0]), 32'd1);

        // Reset during a master access aborts it without an ack.
        clear_acks();
        to_ph(0);
        m_req = 1'b1; m_rnw = 1'b0;
        @(posedge CLK_6M); #2;
        @(posedge CLK_6M); #2;
        check("pre_reset_access", 32'(mbuf), 32'd0);
        nRST = 1'b0;
        #1;
        check("async_reset", 32'({c1h[0], c2h[0], cs2h[0], mbuf[0], mlth1[0], mack[0], mwait[0]}),
              32'h6C);
        repeat (2) @(posedge CLK_6M);
        #2 nRST = 1'b1;
        repeat (12) @(posedge CLK_6M);
        #2;
        check("no_ack_after_abort", 32'(ack_cnt[0][0] + ack_cnt[1][0]), 32'd0);
        m_req = 1'b0;
        @(posedge CLK_6M); #2;
        m_req = 1'b1;
        release_when_acked(1'b1, 1'b0);

        repeat (4) @(posedge CLK_6M);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
